// File: rtl/proc_pkg.sv
// Shared processor definitions: opcodes, the fetch NOP and the
// {pc, ir} bundle handed from the fetch queue to ID.
package proc_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;

    // add $0,$0,$0
    localparam logic [31:0] NOP_INSN = 32'h0000_0020;

    localparam logic [5:0] OP_ADD  = 6'h00;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2b;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_HALT = 6'h3f;

    typedef struct packed {
        logic [XLEN_DEFAULT-1:0] pc;
        logic [XLEN_DEFAULT-1:0] ir;
    } fetch_entry_t;

endpackage

// File: rtl/ifetch_imem.sv
// Synchronous read-only memory, 2**AW words of DW bits, registered dout.
// Ports: clk, en (read enable), addr (word address), dout (read data).
// This build carries the identity image (word k holds k) in place of
// the program.txt image; dout holds its value while en is low.
module ifetch_imem #(
    parameter int unsigned AW = 11,
    parameter int unsigned DW = 32
) (
    input  logic          clk,
    input  logic          en,
    input  logic [AW-1:0] addr,
    output logic [DW-1:0] dout
);

    function automatic logic [DW-1:0] image(input logic [AW-1:0] a);
        return DW'(a);
    endfunction

    always_ff @(posedge clk) begin
        if (en) begin
            dout <= image(addr);
        end
    end

endmodule

// File: rtl/ifetch_queue.sv
// Fetch unit: PC generator, 1-cycle ROM and a prefetch queue of {pc, ir}
// feeding ID over valid/ready.
// Ports: w_clk, w_rst_n (async, active low), w_halt, w_redirect,
// w_redirect_pc, w_ready in; r_valid, r_ir, r_pc, r_pc4, r_count out.
// The queue entries use proc_pkg::fetch_entry_t, so XLEN must equal
// the package width.
module ifetch_queue
    import proc_pkg::*;
#(
    parameter int unsigned     XLEN       = XLEN_DEFAULT,
    parameter int unsigned     IMEM_AW    = 11,
    parameter int unsigned     FIFO_DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter logic [XLEN-1:0] NOP_WORD   = NOP_INSN,
    localparam int unsigned    CW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic            w_clk,
    input  logic            w_rst_n,
    input  logic            w_halt,
    input  logic            w_redirect,
    input  logic [XLEN-1:0] w_redirect_pc,
    input  logic            w_ready,
    output logic            r_valid,
    output logic [XLEN-1:0] r_ir,
    output logic [XLEN-1:0] r_pc,
    output logic [XLEN-1:0] r_pc4,
    output logic [CW-1:0]   r_count
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_if_q;
    logic [XLEN-1:0] last_pc_q;
    logic            inflight_q;
    logic            kill_q;
    logic [PW-1:0]   head_q;
    logic [PW-1:0]   tail_q;
    logic [CW-1:0]   count_q;

    fetch_entry_t    mem_q [FIFO_DEPTH];
    fetch_entry_t    head_e;

    logic [XLEN-1:0] rom_dout;
    logic [XLEN-1:0] target;
    logic [CW:0]     credits;
    logic            valid;
    logic            issue;
    logic            push;
    logic            pop;
    logic [1:0]      unused_pc_lsb;

    assign target        = {w_redirect_pc[XLEN-1:2], 2'b00};
    assign unused_pc_lsb = w_redirect_pc[1:0];

    // The in-flight read holds a slot, so a response always fits.
    assign credits = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
    assign valid   = (count_q != '0);
    assign issue   = !w_halt && !w_redirect
                  && (credits < (CW+1)'(FIFO_DEPTH));

    // A response is dropped if its read was killed or a redirect
    // lands in the arrival cycle.
    assign push = inflight_q && !kill_q && !w_redirect;

    // A pop in a redirect cycle is discarded by ID and ignored here.
    assign pop = valid && w_ready && !w_redirect;

    ifetch_imem #(
        .AW (IMEM_AW),
        .DW (XLEN)
    ) u_imem (
        .clk  (w_clk),
        .en   (issue),
        .addr (pc_q[IMEM_AW+1:2]),
        .dout (rom_dout)
    );

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            pc_q       <= RESET_PC;
            pc_if_q    <= '0;
            last_pc_q  <= '0;
            inflight_q <= 1'b0;
            kill_q     <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
        end else begin
            inflight_q <= issue;
            kill_q     <= w_redirect;
            if (valid) begin
                last_pc_q <= head_e.pc;
            end
            if (issue) begin
                pc_if_q <= pc_q;
                pc_q    <= pc_q + XLEN'(4);
            end
            if (w_redirect) begin
                pc_q    <= target;
                head_q  <= '0;
                tail_q  <= '0;
                count_q <= '0;
            end else begin
                if (push) begin
                    tail_q <= tail_q + PW'(1);
                end
                if (pop) begin
                    head_q <= head_q + PW'(1);
                end
                count_q <= count_q + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge w_clk) begin
        if (push) begin
            mem_q[tail_q] <= '{pc: pc_if_q, ir: rom_dout};
        end
    end

    assign head_e  = mem_q[head_q];
    assign r_valid = valid;
    assign r_ir    = valid ? head_e.ir : NOP_WORD;
    assign r_pc    = valid ? head_e.pc : last_pc_q;
    assign r_pc4   = r_pc + XLEN'(4);
    assign r_count = count_q;

    a_no_overflow : assert property (
        @(posedge w_clk) disable iff (!w_rst_n)
        !(push && !pop && (count_q == CW'(FIFO_DEPTH))));

    a_no_underflow : assert property (
        @(posedge w_clk) disable iff (!w_rst_n)
        !(w_ready && r_valid && (count_q == '0)));

    a_count_range : assert property (
        @(posedge w_clk) disable iff (!w_rst_n)
        count_q <= CW'(FIFO_DEPTH));

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: a vector table checked per cycle,
// plus hand-written reset sequences.
module tb_ifetch_queue;

    localparam logic [31:0] NOP = 32'h0000_0020;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        halt = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        ready = 1'b0;
    logic        valid;
    logic [31:0] ir;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ifetch_queue dut (
        .w_clk         (clk),
        .w_rst_n       (rst_n),
        .w_halt        (halt),
        .w_redirect    (redirect),
        .w_redirect_pc (redirect_pc),
        .w_ready       (ready),
        .r_valid       (valid),
        .r_ir          (ir),
        .r_pc          (pc),
        .r_pc4         (pc4),
        .r_count       (count)
    );

    typedef struct {
        bit          rst;
        bit          rdy;
        bit          hlt;
        bit          rd;
        logic [31:0] rpc;
        bit          v;
        logic [31:0] pc;
        int          cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit rst_i, input bit rdy_i, input bit hlt_i,
                       input bit rd_i, input logic [31:0] rpc_i,
                       input bit v_i, input logic [31:0] pc_i,
                       input int cnt_i);
        vec_t t;
        t.rst = rst_i; t.rdy = rdy_i; t.hlt = hlt_i; t.rd = rd_i;
        t.rpc = rpc_i; t.v = v_i; t.pc = pc_i; t.cnt = cnt_i;
        vecs.push_back(t);
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ROM word k holds k, so the instruction is the word address.
    function automatic logic [31:0] exp_ir(input bit v_i,
                                           input logic [31:0] p);
        logic [31:0] w;
        w = {21'b0, p[12:2]};
        return v_i ? w : NOP;
    endfunction

    task automatic check_out(input string tag, input bit v_i,
                             input logic [31:0] pc_i, input int cnt_i);
        chk({tag, " valid"}, {31'b0, valid}, {31'b0, v_i});
        chk({tag, " ir"}, ir, exp_ir(v_i, pc_i));
        chk({tag, " pc"}, pc, pc_i);
        chk({tag, " pc4"}, pc4, pc_i + 32'd4);
        chk({tag, " count"}, {29'b0, count}, cnt_i[31:0]);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset-released with ready high: stream, then back-pressure
        // and a redirect to 0x100 (low bits ignored) with a read
        // in flight.
        add(1,1,0,0,0, 0,32'h000,0);
        add(0,1,0,0,0, 0,32'h000,0);
        add(0,1,0,0,0, 1,32'h000,1);
        add(0,1,0,0,0, 1,32'h004,1);
        add(0,1,0,0,0, 1,32'h008,1);
        add(0,1,0,0,0, 1,32'h00c,1);
        add(0,0,0,0,0, 1,32'h010,1);
        add(0,0,0,0,0, 1,32'h010,2);
        add(0,0,0,1,32'h103, 1,32'h010,3);
        add(0,1,0,0,0, 0,32'h010,0);
        add(0,1,0,0,0, 0,32'h010,0);
        add(0,1,0,0,0, 1,32'h100,1);
        add(0,1,0,0,0, 1,32'h104,1);
        add(0,1,0,0,0, 1,32'h108,1);
        // Ten cycles stalled: occupancy saturates, then drains
        // without bubbles or duplicates.
        add(1,0,0,0,0, 0,32'h000,0);
        add(0,0,0,0,0, 0,32'h000,0);
        add(0,0,0,0,0, 1,32'h000,1);
        add(0,0,0,0,0, 1,32'h000,2);
        add(0,0,0,0,0, 1,32'h000,3);
        for (int k = 0; k < 5; k++) add(0,0,0,0,0, 1,32'h000,4);
        add(0,1,0,0,0, 1,32'h000,4);
        add(0,1,0,0,0, 1,32'h004,3);
        add(0,1,0,0,0, 1,32'h008,2);
        add(0,1,0,0,0, 1,32'h00c,2);
        add(0,1,0,0,0, 1,32'h010,2);
        add(0,1,0,0,0, 1,32'h014,2);
        add(0,1,0,0,0, 1,32'h018,2);
        // Redirect in the same cycle as a pop from a full queue.
        add(1,0,0,0,0, 0,32'h000,0);
        add(0,0,0,0,0, 0,32'h000,0);
        add(0,0,0,0,0, 1,32'h000,1);
        add(0,0,0,0,0, 1,32'h000,2);
        add(0,0,0,0,0, 1,32'h000,3);
        add(0,0,0,0,0, 1,32'h000,4);
        add(0,1,0,1,32'h200, 1,32'h000,4);
        add(0,1,0,0,0, 0,32'h000,0);
        add(0,1,0,0,0, 0,32'h000,0);
        add(0,1,0,0,0, 1,32'h200,1);
        add(0,1,0,0,0, 1,32'h204,1);
        // Halt with three queued: drain, idle on NOP, resume at 0xC.
        add(1,0,0,0,0, 0,32'h000,0);
        add(0,0,0,0,0, 0,32'h000,0);
        add(0,0,0,0,0, 1,32'h000,1);
        add(0,0,1,0,0, 1,32'h000,2);
        add(0,1,1,0,0, 1,32'h000,3);
        add(0,1,1,0,0, 1,32'h004,2);
        add(0,1,1,0,0, 1,32'h008,1);
        add(0,1,1,0,0, 0,32'h008,0);
        add(0,1,1,0,0, 0,32'h008,0);
        add(0,1,0,0,0, 0,32'h008,0);
        add(0,1,0,0,0, 0,32'h008,0);
        add(0,1,0,0,0, 1,32'h00c,1);
        add(0,1,0,0,0, 1,32'h010,1);

        #1 rst_n = 1'b0;
        #1;
        check_out("por", 1'b0, 32'h0, 0);

        foreach (vecs[i]) begin
            ready       = vecs[i].rdy;
            halt        = vecs[i].hlt;
            redirect    = vecs[i].rd;
            redirect_pc = vecs[i].rpc;
            if (vecs[i].rst) do_reset();
            check_out($sformatf("v%0d", i), vecs[i].v,
                      vecs[i].pc, vecs[i].cnt);
            step();
        end

        // Asynchronous reset in the middle of a cycle while streaming.
        ready = 1'b1; halt = 1'b0; redirect = 1'b0; redirect_pc = '0;
        do_reset();
        for (int k = 0; k < 4; k++) step();
        check_out("pre_arst", 1'b1, 32'h008, 1);
        #3 rst_n = 1'b0;
        #1;
        check_out("arst", 1'b0, 32'h000, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        check_out("rel0", 1'b0, 32'h000, 0);
        step();
        check_out("rel1", 1'b0, 32'h000, 0);
        step();
        check_out("rel2", 1'b1, 32'h000, 1);
        step();
        check_out("rel3", 1'b1, 32'h004, 1);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
